serial_pattern_feeder: RTL and testbench
========================================

# serial_pattern_feeder

Upstream bit source for the serial sequence detectors. It accepts parallel words through a valid/ready handshake and buffers them in a small FIFO. It shifts each word out one bit per clock onto `x`, which drives the detector's `x` input directly. Words stream back-to-back with no gap bits. When no data is queued, the line idles at a fixed level.

## Interface
- `WIDTH`, 8: bits per word; must be ≥ 2.
- `DEPTH`, 4: FIFO entries; must be a power of 2 and ≥ 2.
- `MSB_FIRST`, 1: 1 shifts bit WIDTH-1 first; 0 shifts bit 0 first.
- `IDLE_BIT`, 0: level driven on `x` when no word is being shifted.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `din`  in  WIDTH  word to enqueue.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  FIFO can accept a word; equals `level < DEPTH`.
- `x`  out  1  serial bit to the detector; registered.
- `x_active`  out  1  `x` carries a data bit this cycle; registered.
- `word_done`  out  1  one-cycle pulse while the last bit of a word is on `x`; registered.
- `level`  out  $clog2(DEPTH)+1  number of FIFO entries currently occupied.

## Operation
- **Push:** a word is enqueued on a rising edge where `din_valid && din_ready`.
  - `din_ready` depends only on `level`.
  - When the FIFO is full, a push is refused even if a pop occurs on the same edge.
- **Pop:** the serializer dequeues the head entry when it loads a word. A push and a pop on the same edge leave `level` unchanged.
- **FIFO storage:** circular buffer with read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH. `level` tracks occupancy from 0 to DEPTH.
- **Serializer FSM, state IDLE:**
  - `x` = IDLE_BIT, `x_active` = 0.
  - If `level > 0`: pop, drive the first bit on `x`, load the remaining WIDTH-1 bits into the shift register, set the bit counter to WIDTH-1, go to SHIFT.
- **Serializer FSM, state SHIFT:**
  - Each edge: if the counter is > 0, drive the next bit, shift, and decrement the counter.
  - If the counter is 0 (last bit currently on `x`) and `level > 0`: reload from the FIFO as in IDLE, so there is no idle gap.
  - If the counter is 0 and `level == 0`: go to IDLE, `x` ← IDLE_BIT, `x_active` ← 0.
- **Bit order:** MSB_FIRST=1 sends bits WIDTH-1 down to 0; MSB_FIRST=0 sends bits 0 up to WIDTH-1.
- **`word_done`:** registered alongside `x`; high exactly in the cycle the word's final bit is on `x`.
- **Reset, including mid-word:**
  - Pointers and `level` go to 0.
  - State goes to IDLE.
  - The partially sent word and all queued words are discarded.

## Timing
- **Reset values:** `x` = IDLE_BIT, `x_active` = 0, `word_done` = 0, `level` = 0, `din_ready` = 1.
- **Latency:** a word pushed at edge N into an idle, empty feeder has its first bit on `x` after edge N+1.
- **Bit timing:** each bit is held for exactly one clock. A word therefore occupies exactly WIDTH consecutive `x_active` cycles.
- **Throughput:** one word per WIDTH cycles. Sustained pushes at that rate keep `x_active` continuously high.
- **Output stability:** `x` changes only on rising edges, so the detector samples a stable bit on every edge.

## Test plan
1. **Reset values.** Assert `reset` asynchronously between edges. Required: `x` = 0, `x_active` = 0, `level` = 0, `din_ready` = 1, with no clock edge needed.
2. **Single MSB-first word.** Push 8'hB5 at edge N. Required:
   - After edges N+1 through N+8, `x` = 1,0,1,1,0,1,0,1.
   - `word_done` is high only in the last of those cycles.
   - After edge N+9, `x` returns to IDLE_BIT and `x_active` falls to 0.
3. **Back-to-back words.** Push 8'hFF then 8'h00 on consecutive edges. Required:
   - `x_active` high for 16 consecutive cycles.
   - `x` = eight 1s followed by eight 0s.
   - Two `word_done` pulses, 8 cycles apart.
4. **Full FIFO.** Hold `din_valid` high with an incrementing `din`, starting from empty. Required:
   - `level` saturates at DEPTH and `din_ready` drops.
   - No word is lost or duplicated; the output order matches the push order.
   - `din_ready` rises after the next pop.
5. **Reset mid-word.** Push three words, then assert `reset` while bit 3 of the first word is on `x`. Required:
   - Immediate return to the reset values.
   - After release, nothing is shifted until a new word is pushed.
6. **LSB-first.** With MSB_FIRST=0, push 8'h01. Required: `x` = 1,0,0,0,0,0,0,0. Feeding this into the detector produces its expected `Y` response.

Source files
------------

// File: rtl/serial_pattern_feeder.sv
// Word-to-bit feeder for the serial sequence detectors: a small circular FIFO
// followed by a shift-register serializer that streams words back-to-back onto x.
module serial_pattern_feeder #(
   parameter int   WIDTH     = 8,
   parameter int   DEPTH     = 4,
   parameter int   MSB_FIRST = 1,
   parameter logic IDLE_BIT  = 1'b0
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WIDTH-1:0]         din,
   input  logic                     din_valid,
   output logic                     din_ready,
   output logic                     x,
   output logic                     x_active,
   output logic                     word_done,
   output logic [$clog2(DEPTH):0]   level,
   output logic [0:0]               fsm_state
);

   // Handshake: a word transfers on a rising edge where din_valid && din_ready;
   // din_ready depends only on level, never on din_valid or on a same-edge pop.

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = $clog2(WIDTH);

   localparam logic [0:0]    IDLE  = 1'b0;
   localparam logic [0:0]    SHIFT = 1'b1;
   localparam logic [LW-1:0] FULL  = LW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [0:0]       state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    cnt;

   logic             push;
   logic             load;
   logic [WIDTH-1:0] head;
   logic             first_bit;
   logic [WIDTH-1:0] load_sh;
   logic             next_bit;
   logic [WIDTH-1:0] shifted;

   assign fsm_state = state;

   always_comb begin
      din_ready = (level < FULL);
      push      = din_valid && din_ready;
      // A load both pops the FIFO and puts the new word's first bit on x.
      load      = (level != '0) && ((state == IDLE) || (cnt == '0));
      head      = mem[rd_ptr];
      if (MSB_FIRST != 0) begin
         first_bit = head[WIDTH-1];
         load_sh   = head << 1;
         next_bit  = shreg[WIDTH-1];
         shifted   = shreg << 1;
      end else begin
         first_bit = head[0];
         load_sh   = head >> 1;
         next_bit  = shreg[0];
         shifted   = shreg >> 1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (load) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, load})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         x         <= IDLE_BIT;
         x_active  <= 1'b0;
         word_done <= 1'b0;
         shreg     <= '0;
         cnt       <= '0;
      end else if (load) begin
         state     <= SHIFT;
         x         <= first_bit;
         x_active  <= 1'b1;
         word_done <= 1'b0;
         shreg     <= load_sh;
         cnt       <= CW'(WIDTH - 1);
      end else if ((state == SHIFT) && (cnt != '0)) begin
         x         <= next_bit;
         x_active  <= 1'b1;
         word_done <= (cnt == CW'(1));
         shreg     <= shifted;
         cnt       <= cnt - CW'(1);
      end else begin
         state     <= IDLE;
         x         <= IDLE_BIT;
         x_active  <= 1'b0;
         word_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_serial_pattern_feeder.sv
// Bench for serial_pattern_feeder: word-level reference model feeding an
// expected-bit queue, a negedge monitor, directed scenarios and random traffic.
module tb_serial_pattern_feeder;

   localparam int   W    = 8;
   localparam int   D    = 4;
   localparam int   LW   = $clog2(D) + 1;
   localparam logic IDLE = 1'b0;

   // clock / reset
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   // MSB-first instance
   logic [W-1:0]  din = '0;
   logic          din_valid = 1'b0;
   logic          din_ready, x, x_active, word_done;
   logic [LW-1:0] level;
   logic [0:0]    fsm_state;

   // LSB-first instance
   logic [W-1:0]  l_din = '0;
   logic          l_valid = 1'b0;
   logic          l_ready, l_x, l_active, l_done;
   logic [LW-1:0] l_level;
   logic [0:0]    l_state;

   serial_pattern_feeder #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1), .IDLE_BIT(IDLE)) dut (
      .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .x(x), .x_active(x_active), .word_done(word_done), .level(level), .fsm_state(fsm_state)
   );

   serial_pattern_feeder #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0), .IDLE_BIT(IDLE)) dut_lsb (
      .clk(clk), .reset(reset), .din(l_din), .din_valid(l_valid), .din_ready(l_ready),
      .x(l_x), .x_active(l_active), .word_done(l_done), .level(l_level), .fsm_state(l_state)
   );

   int n_cmp = 0;
   int n_err = 0;
   logic mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: words occupy the line for W cycles each, queued words
   // follow with no gap, and occupancy counts words not yet started.
   logic [1:0] exp_q[$];   // {last_bit, bit}
   int   m_level = 0;
   int   m_bits_left = 0;  // bits of the current word still to show on x, incl. the one now shown
   logic m_acc = 1'b0;
   logic m_pop;
   int   idx;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         m_level = 0;
         m_bits_left = 0;
         m_acc = 1'b0;
      end else begin
         m_pop = (m_bits_left <= 1) && (m_level > 0);
         m_acc = din_valid && (m_level < D);
         if (m_acc) begin
            for (int i = 0; i < W; i++) begin
               idx = W - 1 - i;
               exp_q.push_back({(i == W - 1), din[idx]});
            end
         end
         if (m_pop) m_bits_left = W;
         else if (m_bits_left > 0) m_bits_left--;
         m_level = m_level + int'(m_acc) - int'(m_pop);
      end
   end

   // Monitor: compares the MSB-first instance against the model every cycle.
   logic [1:0] e;
   always @(negedge clk) begin
      if (mon_en && !reset) begin
         check("level", level, m_level);
         check("din_ready", din_ready, (m_level < D));
         if (m_bits_left > 0) begin
            check("x_active", x_active, 1);
            if (exp_q.size() == 0) begin
               check("exp_q_underflow", 0, 1);
            end else begin
               e = exp_q.pop_front();
               check("x_bit", x, e[0]);
               check("word_done", word_done, e[1]);
            end
         end else begin
            check("idle_active", x_active, 0);
            check("idle_x", x, IDLE);
            check("idle_done", word_done, 0);
         end
      end
   end

   task automatic drain();
      int b;
      b = 0;
      while ((m_level != 0 || m_bits_left != 0) && b < 300) begin
         tick();
         b++;
      end
      check("drain_timeout", (b < 300), 1);
      check("drain_active", x_active, 0);
      check("drain_q", exp_q.size(), 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0]  got_w, w0, lw, gd;
      logic [15:0]   act16, bit16, dn16;
      logic          saw_full;
      int            ok;

      // initial reset release
      #12 reset = 1'b0;
      mon_en = 1'b1;
      tick();

      // 1: asynchronous reset between edges with traffic in flight
      din = 8'h3C; din_valid = 1'b1; tick(); din_valid = 1'b0; tick(); tick();
      #2 reset = 1'b1;
      #1;
      check("t1_x", x, IDLE);
      check("t1_x_active", x_active, 0);
      check("t1_word_done", word_done, 0);
      check("t1_level", level, 0);
      check("t1_din_ready", din_ready, 1);
      check("t1_lsb_level", l_level, 0);
      tick(); tick();
      @(negedge clk);
      #2 reset = 1'b0;
      tick();

      // 2: single MSB-first word 8'hB5
      din = 8'hB5; din_valid = 1'b1;
      tick();                     // edge N
      din_valid = 1'b0;
      tick();                     // edge N+1
      check("t2_latency", x_active, 1);
      got_w = '0; gd = '0;
      for (int i = 0; i < W; i++) begin
         got_w[W-1-i] = x;
         gd[W-1-i] = word_done;
         if (i < W - 1) tick();
      end
      check("t2_bits", got_w, 8'hB5);
      check("t2_done", gd, 8'h01);
      tick();                     // edge N+9
      check("t2_end_active", x_active, 0);
      check("t2_end_x", x, IDLE);

      // 3: back-to-back 8'hFF, 8'h00
      din = 8'hFF; din_valid = 1'b1; tick();
      din = 8'h00; tick();
      din_valid = 1'b0;
      for (int i = 0; i < 16; i++) begin
         act16[15-i] = x_active;
         bit16[15-i] = x;
         dn16[15-i]  = word_done;
         if (i < 15) tick();
      end
      check("t3_active", act16, 16'hFFFF);
      check("t3_bits", bit16, 16'hFF00);
      check("t3_done", dn16, 16'h0101);
      tick();
      check("t3_end_active", x_active, 0);

      // 4: full FIFO with incrementing data held valid
      drain();
      din = 8'h10; din_valid = 1'b1; saw_full = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (m_acc) din = din + 8'd1;
         if (level == LW'(D) && !din_ready) saw_full = 1'b1;
      end
      din_valid = 1'b0;
      check("t4_saw_full", saw_full, 1);
      drain();

      // 5: reset while bit 3 of the first word is on x
      w0 = W'($urandom);
      for (int k = 0; k < 3; k++) begin
         din = (k == 0) ? w0 : W'($urandom); din_valid = 1'b1; tick();
      end
      din_valid = 1'b0;
      tick(); tick(); tick();     // edge N+5: bit 3 of w0 on x
      check("t5_bit3", x, w0[3]);
      #2 reset = 1'b1;
      #1;
      check("t5_x", x, IDLE);
      check("t5_x_active", x_active, 0);
      check("t5_level", level, 0);
      check("t5_din_ready", din_ready, 1);
      tick();
      @(negedge clk);
      #2 reset = 1'b0;
      ok = 1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (x_active !== 1'b0 || level !== '0) ok = 0;
      end
      check("t5_quiet_after_reset", ok, 1);

      // 6: LSB-first instance, 8'h01 then random words
      for (int k = 0; k < 4; k++) begin
         lw = (k == 0) ? 8'h01 : W'($urandom);
         l_din = lw; l_valid = 1'b1; tick();
         l_valid = 1'b0; tick();
         got_w = '0; gd = '0;
         for (int i = 0; i < W; i++) begin
            got_w[i] = l_x;
            gd[i] = l_done;
            tick();
         end
         check("t6_lsb_bits", got_w, lw);
         check("t6_lsb_done", gd, 8'h80);
         check("t6_lsb_idle", l_active, 0);
      end

      // random traffic on the MSB-first instance
      for (int c = 0; c < 500; c++) begin
         if (c % 100 < 70) din_valid = ($urandom_range(0, 3) != 0);
         else              din_valid = ($urandom_range(0, 15) == 0);
         din = W'($urandom);
         tick();
      end
      din_valid = 1'b0;
      drain();

      mon_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
